// File: rtl/counter_pkg.sv
// Shared types and helpers for the datapath counter.
// Provides count direction enum and prescaler length function.
package counter_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_mode_e;

  // Prescaler length in clocks for one tick.
  function automatic int tick_cycle(
    input int clk_hz,
    input int tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_gen_param.sv
// Reusable prescaler: 1-clk registered tick every TICK_CYCLE enabled clocks.
// Ports: clk, rst (async active-low), enable, clear (sync), o_tick.
module tick_gen_param
  import counter_pkg::*;
#(
  parameter int TICK_CYCLE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic o_tick
);

  localparam int PW = (TICK_CYCLE > 2) ? $clog2(TICK_CYCLE) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLE - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      o_tick <= 1'b0;
    end else if (clear) begin
      phase  <= '0;
      o_tick <= 1'b0;
    end else if (enable) begin
      if (phase == LAST) begin
        phase  <= '0;
        o_tick <= 1'b1;
      end else begin
        phase  <= phase + PW'(1);
        o_tick <= 1'b0;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/datapath_counter_mod.sv
// Mod-MODULUS up/down counter advanced by a TICK_HZ prescaler tick.
// Ports: clk, rst (async low), mode, enable, clear, [load, load_val],
//   count_reg, o_tick, o_wrap. Macro COUNTER_LOAD_EN adds parallel load.
module datapath_counter_mod
  import counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MODULUS = 10000,
  parameter int COUNT_W = $clog2(MODULUS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               enable,
  input  logic               clear,
`ifdef COUNTER_LOAD_EN
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
`endif
  output logic [COUNT_W-1:0] count_reg,
  output logic               o_tick,
  output logic               o_wrap
);

  localparam int TICK_CYCLE = tick_cycle(CLK_HZ, TICK_HZ);
  localparam int CW1 = COUNT_W + 1;
  localparam logic [CW1-1:0] MAX = CW1'(MODULUS - 1);

  if (TICK_CYCLE < 2) begin : g_bad_tick
    $error("TICK_CYCLE must be >= 2");
  end
  if (MODULUS < 2) begin : g_bad_mod
    $error("MODULUS must be >= 2");
  end
  if (COUNT_W < $clog2(MODULUS)) begin : g_bad_w
    $error("COUNT_W too small for MODULUS");
  end

  logic presc_clr;
  logic [CW1-1:0] cur_ext;
  logic [CW1-1:0] nxt_ext;
  logic [COUNT_W-1:0] nxt_cnt;
  logic nxt_wrap;

`ifdef COUNTER_LOAD_EN
  logic [CW1-1:0] ld_ext;
  logic [COUNT_W-1:0] ld_cnt;

  // Loading restarts the period so the loaded value is held a full tick.
  assign presc_clr = clear | load;
  assign ld_ext = {1'b0, load_val};
  assign ld_cnt = (ld_ext > MAX) ? MAX[COUNT_W-1:0] : load_val;
`else
  assign presc_clr = clear;
`endif

  tick_gen_param #(
    .TICK_CYCLE(TICK_CYCLE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .clear (presc_clr),
    .o_tick(o_tick)
  );

  // One extra bit keeps +1 at the top of a power-of-two range exact.
  always_comb begin
    cur_ext  = {1'b0, count_reg};
    nxt_ext  = cur_ext;
    nxt_wrap = 1'b0;
    if (cnt_mode_e'(mode) == CNT_DOWN) begin
      if (cur_ext == '0) begin
        nxt_ext  = MAX;
        nxt_wrap = 1'b1;
      end else begin
        nxt_ext = cur_ext - CW1'(1);
      end
    end else begin
      if (cur_ext >= MAX) begin
        nxt_ext  = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_ext = cur_ext + CW1'(1);
      end
    end
    nxt_cnt = (nxt_ext > MAX) ? MAX[COUNT_W-1:0] : nxt_ext[COUNT_W-1:0];
  end

  // The registered tick drives the update, so count lags tick by one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      o_wrap    <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      o_wrap    <= 1'b0;
`ifdef COUNTER_LOAD_EN
    end else if (load) begin
      count_reg <= ld_cnt;
      o_wrap    <= 1'b0;
`endif
    end else if (o_tick) begin
      count_reg <= nxt_cnt;
      o_wrap    <= nxt_wrap;
    end else begin
      o_wrap    <= 1'b0;
    end
  end

endmodule
